// File: rtl/presubmult_arbiter.sv
// Two-requester round-robin arbiter in front of a 3-stage pipelined (a-b)*c datapath.
// The result comes back tagged with the id of the requester that issued it.
module presubmult_arbiter #(
    parameter int SIZEIN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     req0_valid,
    input  logic                     req1_valid,
    output logic                     req0_ready,
    output logic                     req1_ready,
    input  logic signed [SIZEIN-1:0] req0_a,
    input  logic signed [SIZEIN-1:0] req0_b,
    input  logic signed [SIZEIN-1:0] req0_c,
    input  logic signed [SIZEIN-1:0] req1_a,
    input  logic signed [SIZEIN-1:0] req1_b,
    input  logic signed [SIZEIN-1:0] req1_c,
    output logic                     res_valid,
    output logic                     res_id,
    output logic signed [2*SIZEIN:0] res_data,
    output logic [1:0]               inflight
);

    localparam int DW = SIZEIN + 1;
    localparam int PW = 2 * SIZEIN + 1;

    // Arbiter state: id of the requester granted by the most recent transfer
    logic r_last_grant;

    // Stage S1
    logic                     r_v1;
    logic                     r_tag1;
    logic signed [DW-1:0]     r_diff;
    logic signed [SIZEIN-1:0] r_c;

    // Stage S2
    logic                     r_v2;
    logic                     r_tag2;
    logic signed [PW-1:0]     r_m;

    // Stage S3
    logic                     r_v3;
    logic                     r_tag3;
    logic signed [PW-1:0]     r_p;

    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_xfer;
    logic                     w_xfer_id;
    logic signed [SIZEIN-1:0] w_sel_a;
    logic signed [SIZEIN-1:0] w_sel_b;
    logic signed [SIZEIN-1:0] w_sel_c;
    logic signed [DW-1:0]     w_diff;
    logic signed [PW-1:0]     w_diff_ext;
    logic signed [PW-1:0]     w_c_ext;
    logic signed [PW-1:0]     w_mult;

    // Round-robin grant: a lone requester wins; on contention the one not granted last wins
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant0 = r_last_grant;
            w_grant1 = ~r_last_grant;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    assign req0_ready = ce & ~rst & w_grant0;
    assign req1_ready = ce & ~rst & w_grant1;
    assign w_xfer     = req0_ready | req1_ready;
    assign w_xfer_id  = req1_ready;

    // Operand mux and pre-subtract; both operands widened by one bit so a-b never overflows
    always_comb begin
        w_sel_a = w_xfer_id ? req1_a : req0_a;
        w_sel_b = w_xfer_id ? req1_b : req0_b;
        w_sel_c = w_xfer_id ? req1_c : req0_c;
        w_diff  = $signed({w_sel_a[SIZEIN-1], w_sel_a}) - $signed({w_sel_b[SIZEIN-1], w_sel_b});
    end

    // Full-width product: operands sign-extended to the product width first
    assign w_diff_ext = $signed({{SIZEIN{r_diff[DW-1]}}, r_diff});
    assign w_c_ext    = $signed({{(SIZEIN + 1){r_c[SIZEIN-1]}}, r_c});
    assign w_mult     = w_diff_ext * w_c_ext;

    // Round-robin pointer; only moves on an accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_xfer_id;
        end
    end

    // S1 capture; data registers only load on a transfer so they hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_tag1 <= 1'b0;
            r_diff <= '0;
            r_c    <= '0;
        end else if (ce) begin
            r_v1 <= w_xfer;
            if (w_xfer) begin
                r_tag1 <= w_xfer_id;
                r_diff <= w_diff;
                r_c    <= w_sel_c;
            end
        end
    end

    // S2 multiply; data follows the valid so idle cycles leave it untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_tag2 <= 1'b0;
            r_m    <= '0;
        end else if (ce) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_tag2 <= r_tag1;
                r_m    <= w_mult;
            end
        end
    end

    // S3 output register; res_data keeps the last result between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_tag3 <= 1'b0;
            r_p    <= '0;
        end else if (ce) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_tag3 <= r_tag2;
                r_p    <= r_m;
            end
        end
    end

    // Outputs forced to zero while reset is asserted, before the registers have cleared
    always_comb begin
        res_valid = r_v3 & ~rst;
        res_id    = r_tag3 & ~rst;
        res_data  = rst ? '0 : r_p;
        inflight  = rst ? 2'd0 : ({1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3});
    end

endmodule

// File: tb/tb_presubmult_arbiter.sv
// Directed bench for presubmult_arbiter: one task per scenario, inline comparisons.
module tb_presubmult_arbiter;

    localparam int SIZEIN = 16;

    logic                     clk;
    logic                     rst;
    logic                     ce;
    logic                     req0_valid;
    logic                     req1_valid;
    logic                     req0_ready;
    logic                     req1_ready;
    logic signed [SIZEIN-1:0] req0_a;
    logic signed [SIZEIN-1:0] req0_b;
    logic signed [SIZEIN-1:0] req0_c;
    logic signed [SIZEIN-1:0] req1_a;
    logic signed [SIZEIN-1:0] req1_b;
    logic signed [SIZEIN-1:0] req1_c;
    logic                     res_valid;
    logic                     res_id;
    logic signed [2*SIZEIN:0] res_data;
    logic [1:0]               inflight;

    int errors = 0;
    int checks = 0;

    presubmult_arbiter #(.SIZEIN(SIZEIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_data   (res_data),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ce         = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        ce         = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        ce = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
        end
        checks++;
        if (res_valid !== 1'b0 || res_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_res: valid=%b id=%b required 0 0", res_valid, res_id);
        end
        checks++;
        if (res_data !== 33'sd0) begin
            errors++;
            $display("FAIL reset_data: got %0d required 0", res_data);
        end
        checks++;
        if (inflight !== 2'd0) begin
            errors++;
            $display("FAIL reset_inflight: got %0d required 0", inflight);
        end
        tick();
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // a=5 b=3 c=-4 on req0 -> -8 three cycles after the transfer
    task automatic test_single();
        logic [1:0] inf_tab [4];
        inf_tab = '{2'd1, 2'd1, 2'd1, 2'd0};
        req0_valid = 1'b1;
        req0_a = 16'sd5;
        req0_b = 16'sd3;
        req0_c = -16'sd4;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got %b%b required 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inflight !== inf_tab[i]) begin
                errors++;
                $display("FAIL single_inflight[%0d]: got %0d required %0d", i, inflight,
                         inf_tab[i]);
            end
            checks++;
            if (res_valid !== (i == 2)) begin
                errors++;
                $display("FAIL single_valid[%0d]: got %b required %b", i, res_valid, (i == 2));
            end
            if (i >= 2) begin
                checks++;
                if (res_id !== 1'b0 || res_data !== -33'sd8) begin
                    errors++;
                    $display("FAIL single_result[%0d]: id=%b data=%0d required id=0 data=-8",
                             i, res_id, res_data);
                end
            end
            tick();
        end
    endtask

    // Both requesters valid for 4 cycles: grants 0,1,0,1 and results in the same order
    task automatic test_contention();
        logic [1:0]        inf_tab [8];
        logic              exp_id;
        logic signed [32:0] exp_d;
        inf_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        req0_a = 16'sd10;
        req0_b = 16'sd4;
        req0_c = 16'sd3;
        req1_a = -16'sd7;
        req1_b = 16'sd2;
        req1_c = 16'sd5;
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i < 4);
            req1_valid = (i < 4);
            #1;
            if (i < 4) begin
                checks++;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL contention_grant[%0d]: got %b%b required %b%b", i,
                             req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
                end
            end
            checks++;
            if (res_valid !== (i >= 3 && i <= 6)) begin
                errors++;
                $display("FAIL contention_valid[%0d]: got %b required %b", i, res_valid,
                         (i >= 3 && i <= 6));
            end
            if (i >= 3 && i <= 6) begin
                exp_id = ((i - 3) % 2 == 1);
                exp_d  = exp_id ? -33'sd45 : 33'sd18;
                checks++;
                if (res_id !== exp_id || res_data !== exp_d) begin
                    errors++;
                    $display("FAIL contention_result[%0d]: id=%b data=%0d required id=%b data=%0d",
                             i, res_id, res_data, exp_id, exp_d);
                end
            end
            checks++;
            if (inflight !== inf_tab[i]) begin
                errors++;
                $display("FAIL contention_inflight[%0d]: got %0d required %0d", i, inflight,
                         inf_tab[i]);
            end
            tick();
        end
    endtask

    // Extreme operands back-to-back on req0
    task automatic test_extremes();
        req0_valid = 1'b1;
        req0_a = 16'sh8000;
        req0_b = 16'sh7FFF;
        req0_c = 16'sh8000;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL extremes_ready0: got %b required 1", req0_ready);
        end
        tick();
        req0_a = 16'sh7FFF;
        req0_b = 16'sh8000;
        req0_c = 16'sh8000;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL extremes_ready1: got %b required 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 33'sd2147450880) begin
            errors++;
            $display("FAIL extremes_pos: valid=%b data=%0d required 1 2147450880", res_valid,
                     res_data);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== -33'sd2147450880) begin
            errors++;
            $display("FAIL extremes_neg: valid=%b data=%0d required 1 -2147450880", res_valid,
                     res_data);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || res_data !== -33'sd2147450880) begin
            errors++;
            $display("FAIL extremes_hold: valid=%b data=%0d required 0 -2147450880", res_valid,
                     res_data);
        end
    endtask

    // Transfer, 5 stalled cycles, then the result after 2 more enabled cycles
    task automatic test_ce_stall();
        req0_valid = 1'b1;
        req0_a = 16'sd9;
        req0_b = 16'sd2;
        req0_c = 16'sd6;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_xfer: got %b required 1", req0_ready);
        end
        tick();
        ce         = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b%b required 00", i, req0_ready, req1_ready);
            end
            checks++;
            if (inflight !== 2'd1 || res_valid !== 1'b0 || res_data !== -33'sd2147450880) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: inflight=%0d valid=%b data=%0d required 1 0 -2147450880",
                         i, inflight, res_valid, res_data);
            end
            tick();
        end
        ce         = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_early[%0d]: got %b required 0", i, res_valid);
            end
            tick();
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 33'sd42 || res_id !== 1'b0) begin
            errors++;
            $display("FAIL stall_result: valid=%b id=%b data=%0d required 1 0 42", res_valid,
                     res_id, res_data);
        end
        ce = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 33'sd42) begin
            errors++;
            $display("FAIL stall_hold_pulse: valid=%b data=%0d required 1 42", res_valid, res_data);
        end
        ce = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_pulse_end: got %b required 0", res_valid);
        end
    endtask

    // Three ops in flight via req0, reset flushes them, req0 wins next contention
    task automatic test_reset_flush();
        req0_valid = 1'b1;
        req0_a = 16'sd1;
        req0_b = 16'sd0;
        req0_c = 16'sd1;
        tick();
        tick();
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (inflight !== 2'd3) begin
            errors++;
            $display("FAIL flush_pre_inflight: got %0d required 3", inflight);
        end
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (inflight !== 2'd0 || res_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        begin
            errors++;
            $display("FAIL flush_during: inflight=%0d valid=%b ready=%b%b required 0 0 00",
                     inflight, res_valid, req0_ready, req1_ready);
        end
        tick();
        rst    = 1'b0;
        req0_a = 16'sd2;
        req0_b = 16'sd1;
        req0_c = 16'sd7;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: got %b%b required 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== (i == 2)) begin
                errors++;
                $display("FAIL flush_valid[%0d]: got %b required %b", i, res_valid, (i == 2));
            end
            tick();
        end
    endtask

    // req1 held valid while req0 toggles: req1 must be granted every other cycle
    task automatic test_fairness();
        int gap;
        do_reset();
        gap        = 0;
        req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i % 2 == 0);
            #1;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL fairness_grant[%0d]: got %b%b required %b%b", i, req0_ready,
                         req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            gap = req1_ready ? 0 : gap + 1;
            checks++;
            if (gap > 2) begin
                errors++;
                $display("FAIL fairness_starve[%0d]: req1 waited %0d cycles, allowed 2", i, gap);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        ce         = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req0_b = '0;
        req0_c = '0;
        req1_a = '0;
        req1_b = '0;
        req1_c = '0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_extremes();
        test_ce_stall();
        test_reset_flush();
        test_fairness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
